// File: rtl/rf_pkg.sv
// Shared sizing and constants for the ROB-tagged register file.
package rf_pkg;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int TAG_W = 4;
    localparam int N_RP  = 4;
    localparam int N_WP  = 2;
    localparam int IDX_W = $clog2(NREGS);
    localparam logic [TAG_W-1:0] TAG_NONE = '0;
endpackage

// File: rtl/rf_commit_arbiter.sv
// Combinational resolve of all commit ports against one queried register index.
// Highest valid port wins the data; any valid port whose tag matches q_tag retires it.
module rf_commit_arbiter
    import rf_pkg::*;
#(
    parameter int P_XLEN  = XLEN,
    parameter int P_TAG_W = TAG_W,
    parameter int P_IDX_W = IDX_W,
    parameter int P_N_WP  = N_WP
) (
    input  logic [P_N_WP-1:0]         wp_en,
    input  logic [P_N_WP*P_IDX_W-1:0] wp_idx,
    input  logic [P_N_WP*P_TAG_W-1:0] wp_tag,
    input  logic [P_N_WP*P_XLEN-1:0]  wp_data,
    input  logic [P_IDX_W-1:0]        q_idx,
    input  logic [P_TAG_W-1:0]        q_tag,
    output logic                      win_vld,
    output logic [P_XLEN-1:0]         win_data,
    output logic                      retire_hit
);
    always_comb begin
        win_vld    = 1'b0;
        win_data   = '0;
        retire_hit = 1'b0;
        // Ascending scan: a later (younger) port overrides an earlier one.
        for (int p = 0; p < P_N_WP; p++) begin
            if (wp_en[p] && (wp_idx[p*P_IDX_W +: P_IDX_W] != '0)
                && (wp_tag[p*P_TAG_W +: P_TAG_W] != '0)
                && (wp_idx[p*P_IDX_W +: P_IDX_W] == q_idx)) begin
                win_vld  = 1'b1;
                win_data = wp_data[p*P_XLEN +: P_XLEN];
                if (wp_tag[p*P_TAG_W +: P_TAG_W] == q_tag) retire_hit = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rob_tagged_regfile_mp.sv
// Multi-port register file with per-register ROB rename tags; reads are registered (1 cycle).
// No backpressure. RF_RENAME_BYPASS_EN forwards a same-cycle rename tag to matching reads.
module rob_tagged_regfile_mp
    import rf_pkg::*;
#(
    parameter int P_XLEN  = XLEN,
    parameter int P_NREGS = NREGS,
    parameter int P_TAG_W = TAG_W,
    parameter int P_N_RP  = N_RP,
    parameter int P_N_WP  = N_WP,
    parameter int P_IDX_W = $clog2(P_NREGS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [P_N_WP-1:0]         wp_en,
    input  logic [P_N_WP*P_IDX_W-1:0] wp_idx,
    input  logic [P_N_WP*P_TAG_W-1:0] wp_tag,
    input  logic [P_N_WP*P_XLEN-1:0]  wp_data,
    input  logic                      dp_en,
    input  logic [P_IDX_W-1:0]        dp_idx,
    input  logic [P_TAG_W-1:0]        dp_tag,
    input  logic                      flush,
    input  logic [P_N_RP*P_IDX_W-1:0] rp_idx,
    output logic [P_N_RP*P_XLEN-1:0]  rp_data,
    output logic [P_N_RP*P_TAG_W-1:0] rp_tag,
    output logic [P_IDX_W:0]          busy_cnt,
    input  logic [P_IDX_W-1:0]        dbg_idx,
    output logic [P_XLEN-1:0]         dbg_data,
    output logic [P_TAG_W-1:0]        dbg_tag
);
    logic [P_XLEN-1:0]  regs      [P_NREGS];
    logic [P_TAG_W-1:0] tags      [P_NREGS];
    logic [P_XLEN-1:0]  regs_nxt  [P_NREGS];
    logic [P_TAG_W-1:0] tags_nxt  [P_NREGS];
    logic               reg_vld   [P_NREGS];
    logic [P_XLEN-1:0]  reg_wdat  [P_NREGS];
    logic               reg_ret   [P_NREGS];
    logic [P_IDX_W:0]   busy_nxt;

    logic [P_IDX_W-1:0] rd_idx    [P_N_RP];
    logic               rd_vld    [P_N_RP];
    logic [P_XLEN-1:0]  rd_wdat   [P_N_RP];
    logic               rd_ret    [P_N_RP];
    logic [P_N_RP-1:0][P_XLEN-1:0]  rd_data_nxt, rd_data_q;
    logic [P_N_RP-1:0][P_TAG_W-1:0] rd_tag_nxt,  rd_tag_q;

    logic ren_vld;
    assign ren_vld = dp_en && (dp_idx != '0) && (dp_tag != TAG_NONE);

    for (genvar i = 0; i < P_NREGS; i++) begin : g_reg_arb
        rf_commit_arbiter #(.P_XLEN(P_XLEN), .P_TAG_W(P_TAG_W), .P_IDX_W(P_IDX_W), .P_N_WP(P_N_WP)) u_arb (
            .wp_en(wp_en), .wp_idx(wp_idx), .wp_tag(wp_tag), .wp_data(wp_data),
            .q_idx(P_IDX_W'(i)), .q_tag(tags[i]),
            .win_vld(reg_vld[i]), .win_data(reg_wdat[i]), .retire_hit(reg_ret[i])
        );
    end

    for (genvar k = 0; k < P_N_RP; k++) begin : g_rd_arb
        assign rd_idx[k] = rp_idx[k*P_IDX_W +: P_IDX_W];
        rf_commit_arbiter #(.P_XLEN(P_XLEN), .P_TAG_W(P_TAG_W), .P_IDX_W(P_IDX_W), .P_N_WP(P_N_WP)) u_arb (
            .wp_en(wp_en), .wp_idx(wp_idx), .wp_tag(wp_tag), .wp_data(wp_data),
            .q_idx(rd_idx[k]), .q_tag(tags[rd_idx[k]]),
            .win_vld(rd_vld[k]), .win_data(rd_wdat[k]), .retire_hit(rd_ret[k])
        );
    end

    // Tag priority, lowest to highest: hold, retire, rename, flush.
    always_comb begin
        busy_nxt = '0;
        for (int i = 0; i < P_NREGS; i++) begin
            regs_nxt[i] = reg_vld[i] ? reg_wdat[i] : regs[i];
            tags_nxt[i] = tags[i];
            if (reg_ret[i]) tags_nxt[i] = TAG_NONE;
            if (ren_vld && (dp_idx == P_IDX_W'(i))) tags_nxt[i] = dp_tag;
            if (flush || (i == 0)) tags_nxt[i] = TAG_NONE;
            if (i == 0) regs_nxt[i] = '0;
            busy_nxt = busy_nxt + {{P_IDX_W{1'b0}}, (tags_nxt[i] != TAG_NONE)};
        end
    end

    always_comb begin
        for (int k = 0; k < P_N_RP; k++) begin
            rd_data_nxt[k] = rd_vld[k] ? rd_wdat[k] : regs[rd_idx[k]];
            rd_tag_nxt[k]  = tags[rd_idx[k]];
            // A rename on the same index blocks the retire, so the old tag still stands.
            if (rd_ret[k] && !(ren_vld && (dp_idx == rd_idx[k]))) rd_tag_nxt[k] = TAG_NONE;
`ifdef RF_RENAME_BYPASS_EN
            if (ren_vld && (dp_idx == rd_idx[k])) rd_tag_nxt[k] = dp_tag;
`endif
            if (flush) rd_tag_nxt[k] = TAG_NONE;
            if (rd_idx[k] == '0) begin
                rd_data_nxt[k] = '0;
                rd_tag_nxt[k]  = TAG_NONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < P_NREGS; i++) begin
                regs[i] <= '0;
                tags[i] <= TAG_NONE;
            end
            rd_data_q <= '0;
            rd_tag_q  <= '0;
            busy_cnt  <= '0;
        end else begin
            regs      <= regs_nxt;
            tags      <= tags_nxt;
            rd_data_q <= rd_data_nxt;
            rd_tag_q  <= rd_tag_nxt;
            busy_cnt  <= busy_nxt;
        end
    end

    assign rp_data  = rd_data_q;
    assign rp_tag   = rd_tag_q;
    assign dbg_data = regs[dbg_idx];
    assign dbg_tag  = tags[dbg_idx];
endmodule

// File: tb/tb_rob_tagged_regfile_mp.sv
// Directed plus randomized bench for rob_tagged_regfile_mp against an array-based reference model.
module tb_rob_tagged_regfile_mp;
    import rf_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic [N_WP-1:0]             wp_en;
    logic [N_WP-1:0][IDX_W-1:0]  wp_idx;
    logic [N_WP-1:0][TAG_W-1:0]  wp_tag;
    logic [N_WP-1:0][XLEN-1:0]   wp_data;
    logic                        dp_en;
    logic [IDX_W-1:0]            dp_idx;
    logic [TAG_W-1:0]            dp_tag;
    logic                        flush;
    logic [N_RP-1:0][IDX_W-1:0]  rp_idx;
    logic [N_RP-1:0][XLEN-1:0]   rp_data;
    logic [N_RP-1:0][TAG_W-1:0]  rp_tag;
    logic [IDX_W:0]              busy_cnt;
    logic [IDX_W-1:0]            dbg_idx;
    logic [XLEN-1:0]             dbg_data;
    logic [TAG_W-1:0]            dbg_tag;

    int n_chk = 0;
    int n_err = 0;

    logic [XLEN-1:0]  m_regs [NREGS];
    logic [TAG_W-1:0] m_tags [NREGS];

    rob_tagged_regfile_mp dut (
        .clk(clk), .rst(rst),
        .wp_en(wp_en), .wp_idx(wp_idx), .wp_tag(wp_tag), .wp_data(wp_data),
        .dp_en(dp_en), .dp_idx(dp_idx), .dp_tag(dp_tag), .flush(flush),
        .rp_idx(rp_idx), .rp_data(rp_data), .rp_tag(rp_tag), .busy_cnt(busy_cnt),
        .dbg_idx(dbg_idx), .dbg_data(dbg_data), .dbg_tag(dbg_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic bit port_ok(int p);
        return wp_en[p] && (wp_idx[p] != 0) && (wp_tag[p] != 0);
    endfunction

    function automatic bit ren_ok();
        return dp_en && (dp_idx != 0) && (dp_tag != 0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = '0;
            m_tags[i] = '0;
        end
    endtask

    task automatic idle();
        wp_en = '0; wp_idx = '0; wp_tag = '0; wp_data = '0;
        dp_en = 1'b0; dp_idx = '0; dp_tag = '0; flush = 1'b0;
    endtask

    // One clock: predict from the current model and inputs, clock, then compare.
    task automatic step();
        logic [XLEN-1:0]  e_data [N_RP];
        logic [TAG_W-1:0] e_tag  [N_RP];
        logic [TAG_W-1:0] nt     [NREGS];
        int busy;
        int di;
        for (int k = 0; k < N_RP; k++) begin
            int ix = int'(rp_idx[k]);
            bit retire = 1'b0;
            e_data[k] = m_regs[ix];
            for (int p = 0; p < N_WP; p++)
                if (port_ok(p) && int'(wp_idx[p]) == ix) begin
                    e_data[k] = wp_data[p];
                    if (wp_tag[p] == m_tags[ix]) retire = 1'b1;
                end
            if (ren_ok() && int'(dp_idx) == ix) begin
`ifdef RF_RENAME_BYPASS_EN
                e_tag[k] = dp_tag;
`else
                e_tag[k] = m_tags[ix];
`endif
            end else
                e_tag[k] = retire ? '0 : m_tags[ix];
            if (flush) e_tag[k] = '0;
            if (ix == 0) begin
                e_data[k] = '0;
                e_tag[k]  = '0;
            end
        end
        for (int i = 0; i < NREGS; i++) nt[i] = m_tags[i];
        for (int p = 0; p < N_WP; p++)
            if (port_ok(p) && m_tags[wp_idx[p]] == wp_tag[p]) nt[wp_idx[p]] = '0;
        if (ren_ok()) nt[dp_idx] = dp_tag;
        if (flush) for (int i = 0; i < NREGS; i++) nt[i] = '0;
        for (int p = 0; p < N_WP; p++)
            if (port_ok(p)) m_regs[wp_idx[p]] = wp_data[p];
        busy = 0;
        for (int i = 0; i < NREGS; i++) begin
            m_tags[i] = nt[i];
            if (nt[i] != 0) busy++;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < N_RP; k++) begin
            chk($sformatf("rp_data%0d", k), rp_data[k], e_data[k]);
            chk($sformatf("rp_tag%0d", k), rp_tag[k], e_tag[k]);
        end
        chk("busy_cnt", busy_cnt, busy);
        di = $urandom_range(0, NREGS - 1);
        dbg_idx = IDX_W'(di);
        #1;
        chk("dbg_data", dbg_data, m_regs[di]);
        chk("dbg_tag", dbg_tag, m_tags[di]);
    endtask

    task automatic sweep(input string name);
        for (int i = 0; i < NREGS; i++) begin
            dbg_idx = IDX_W'(i);
            #1;
            chk({name, "_data"}, dbg_data, m_regs[i]);
            chk({name, "_tag"}, dbg_tag, m_tags[i]);
        end
    endtask

    task automatic randomize_inputs();
        wp_en = N_WP'($urandom);
        for (int p = 0; p < N_WP; p++) begin
            wp_idx[p]  = IDX_W'($urandom_range(0, 7));
            wp_tag[p]  = $urandom_range(0, 1) ? m_tags[wp_idx[p]] : TAG_W'($urandom_range(0, 15));
            wp_data[p] = $urandom;
        end
        dp_en  = $urandom_range(0, 1) == 1;
        dp_idx = IDX_W'($urandom_range(0, 7));
        dp_tag = TAG_W'($urandom_range(0, 15));
        flush  = $urandom_range(0, 19) == 0;
        for (int k = 0; k < N_RP; k++)
            case ($urandom_range(0, 3))
                0:       rp_idx[k] = dp_idx;
                1:       rp_idx[k] = wp_idx[$urandom_range(0, N_WP - 1)];
                default: rp_idx[k] = IDX_W'($urandom_range(0, 7));
            endcase
    endtask

    initial begin
        rst = 1'b0;
        idle();
        rp_idx = '0;
        dbg_idx = '0;
        model_reset();
        #22;
        chk("reset_busy", busy_cnt, 0);
        chk("reset_rp_data", rp_data, 0);
        chk("reset_rp_tag", rp_tag, 0);
        sweep("reset");
        @(negedge clk);
        rst = 1'b1;

        // Read every index after reset.
        for (int g = 0; g < NREGS / N_RP; g++) begin
            for (int k = 0; k < N_RP; k++) rp_idx[k] = IDX_W'(g * N_RP + k);
            step();
        end

        // Rename then retire r5.
        dp_en = 1'b1; dp_idx = 5; dp_tag = 3; rp_idx = '0; rp_idx[0] = 5;
        step();
        idle();
        dbg_idx = 5; #1;
        chk("t2_tag_after_dp", dbg_tag, 3);
        chk("t2_busy_after_dp", busy_cnt, 1);
        wp_en[0] = 1'b1; wp_idx[0] = 5; wp_tag[0] = 3; wp_data[0] = 32'hDEADBEEF;
        step();
        idle();
        chk("t2_rd_data", rp_data[0], 32'hDEADBEEF);
        chk("t2_rd_tag", rp_tag[0], 0);
        chk("t2_busy_after_commit", busy_cnt, 0);

        // Stale retire on r7.
        dp_en = 1'b1; dp_idx = 7; dp_tag = 2; step();
        dp_tag = 6; step();
        idle();
        wp_en[0] = 1'b1; wp_idx[0] = 7; wp_tag[0] = 2; wp_data[0] = 32'h11;
        step();
        idle();
        dbg_idx = 7; #1;
        chk("t3_data", dbg_data, 32'h11);
        chk("t3_tag", dbg_tag, 6);

        // Two ports commit the same register; the younger port wins.
        dp_en = 1'b1; dp_idx = 9; dp_tag = 4; step();
        idle();
        wp_en = '1; wp_idx[0] = 9; wp_idx[1] = 9; wp_tag[0] = 4; wp_tag[1] = 4;
        wp_data[0] = 32'hA; wp_data[1] = 32'hB; rp_idx[1] = 9;
        step();
        idle();
        chk("t4_rd_data", rp_data[1], 32'hB);
        dbg_idx = 9; #1;
        chk("t4_data", dbg_data, 32'hB);
        chk("t4_tag", dbg_tag, 0);

        // Rename and retire of the same register in one cycle.
        dp_en = 1'b1; dp_idx = 3; dp_tag = 1; step();
        dp_tag = 5; wp_en[0] = 1'b1; wp_idx[0] = 3; wp_tag[0] = 1; wp_data[0] = 32'h33;
        rp_idx[2] = 3;
        step();
        idle();
`ifdef RF_RENAME_BYPASS_EN
        chk("t5_rd_tag", rp_tag[2], 5);
`else
        chk("t5_rd_tag", rp_tag[2], 1);
`endif
        dbg_idx = 3; #1;
        chk("t5_tag", dbg_tag, 5);

        // Flush with pending tags and a concurrent commit.
        for (int i = 0; i < 4; i++) begin
            dp_en = 1'b1; dp_idx = IDX_W'(10 + i); dp_tag = TAG_W'(7 + i);
            step();
        end
        idle();
        flush = 1'b1; wp_en[0] = 1'b1; wp_idx[0] = 4; wp_tag[0] = 9; wp_data[0] = 32'h77;
        step();
        idle();
        chk("t6_busy", busy_cnt, 0);
        dbg_idx = 4; #1;
        chk("t6_data", dbg_data, 32'h77);
        sweep("t6");

        // Random traffic with one asynchronous reset in the middle.
        for (int c = 0; c < 400; c++) begin
            randomize_inputs();
            step();
            if (c == 200) begin
                #2;
                rst = 1'b0;
                #1;
                chk("midrst_rp_data", rp_data, 0);
                chk("midrst_rp_tag", rp_tag, 0);
                chk("midrst_busy", busy_cnt, 0);
                model_reset();
                sweep("midrst");
                @(negedge clk);
                rst = 1'b1;
            end
        end
        idle();
        step();
        sweep("final");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
